// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_en.sv
// gf180mcu_fd_sc_mcu7t5v0__clkdiv_en: glitch-free programmable clock divider with EN/ACK handshake
// Ratio changes and start/stop take effect only on full CLKO period boundaries.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_en #(
    parameter int DIV_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [DIV_W-1:0] DIV,
    output logic             CLKO,
    output logic             ACK,
    output logic             TICK,
    inout  wire              VDD,
    inout  wire              VSS
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t           r_state, w_state;
    logic [DIV_W-1:0] r_cnt, w_cnt, r_div, w_div;
    logic             r_clko, w_clko, r_ack, w_ack, r_tick, w_tick, w_last;
    logic             w_unused_supply;
    assign w_unused_supply = VDD ^ VSS;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_clko  <= 1'b0;
            r_ack   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_div   <= w_div;
            r_clko  <= w_clko;
            r_ack   <= w_ack;
            r_tick  <= w_tick;
        end
    end
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_div   = r_div;
        w_clko  = r_clko;
        w_ack   = r_ack;
        w_tick  = 1'b0;
        w_last  = (r_cnt == r_div);
        case (r_state)
            IDLE: begin
                w_clko = 1'b0;
                w_ack  = 1'b0;
                if (EN) begin
                    w_state = RUN;
                    w_clko  = 1'b1;
                    w_ack   = 1'b1;
                    w_tick  = 1'b1;
                    w_div   = DIV;
                    w_cnt   = '0;
                end
            end
            RUN: begin
                w_cnt = w_last ? '0 : r_cnt + 1'b1;
                if (w_last && r_clko) begin
                    w_clko  = 1'b0;
                    w_state = EN ? RUN : DRAIN;
                end else if (w_last && EN) begin
                    // new ratio is only accepted at the start of a period
                    w_clko = 1'b1;
                    w_tick = 1'b1;
                    w_div  = DIV;
                end else if (w_last) begin
                    w_state = IDLE;
                    w_ack   = 1'b0;
                end
            end
            DRAIN: begin
                w_cnt   = w_last ? '0 : r_cnt + 1'b1;
                w_state = w_last ? IDLE : DRAIN;
                w_ack   = ~w_last;
            end
            default: w_state = IDLE;
        endcase
    end
    assign CLKO = r_clko;
    assign ACK  = r_ack;
    assign TICK = r_tick;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_en.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_en: scoreboard bench for the clock divider
// The reference model tracks position within a CLKO period and applies the period-boundary rules.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_en;
    localparam int DIV_W = 4;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic             clko, ack, tick;
    wire              vdd = 1'b1;
    wire              vss = 1'b0;
    int               checks = 0;
    int               failures = 0;
    logic [2:0]       exp_q[$];
    bit               m_run = 1'b0;
    bit               m_sp = 1'b0;
    int               m_pos = 0;
    int               m_d = 0;
    logic [2:0]       m_last = 3'b000;

    gf180mcu_fd_sc_mcu7t5v0__clkdiv_en #(.DIV_W(DIV_W)) dut (
        .CLK(clk), .RST(rst), .EN(en), .DIV(div),
        .CLKO(clko), .ACK(ack), .TICK(tick), .VDD(vdd), .VSS(vss)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: clko/ack/tick got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One source-clock edge: returns expected {CLKO, ACK, TICK} after it.
    task automatic model_edge(input bit e, input int dv, output logic [2:0] o);
        if (!m_run) begin
            if (e) begin
                m_run = 1'b1;
                m_pos = 0;
                m_d   = dv;
                m_sp  = 1'b0;
                o     = 3'b111;
            end else o = 3'b000;
        end else begin
            m_pos++;
            if (m_pos == m_d + 1 && !e) m_sp = 1'b1;
            if (m_pos == 2 * (m_d + 1) && (m_sp || !e)) begin
                m_run = 1'b0;
                o     = 3'b000;
            end else if (m_pos == 2 * (m_d + 1)) begin
                m_pos = 0;
                m_d   = dv;
                m_sp  = 1'b0;
                o     = 3'b111;
            end else o = {m_pos <= m_d, 1'b1, 1'b0};
        end
    endtask

    task automatic step(input bit e, input int dv);
        logic [2:0] o;
        en  = e;
        div = dv[DIV_W-1:0];
        @(posedge clk);
        model_edge(e, dv, o);
        exp_q.push_back(o);
        m_last = o;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        en  = 1'b1;
        #1;
        check("async_reset", {clko, ack, tick}, 3'b000);
        @(posedge clk);
        #1;
        check("reset_hold", {clko, ack, tick}, 3'b000);
        m_run  = 1'b0;
        m_sp   = 1'b0;
        m_last = 3'b000;
        rst    = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check("cycle", {clko, ack, tick}, exp_q.pop_front());
        end
    end

    initial begin
        bit e;
        int dv;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {clko, ack, tick}, 3'b000);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, 0);
        for (int i = 0; i < 6; i++) step(1'b0, 0);
        for (int i = 0; i < 14; i++) step(1'b1, 2);
        for (int i = 0; i < 12 && !(m_run && m_pos == 1); i++) step(1'b1, 2);
        for (int i = 0; i < 30; i++) step(1'b1, 5);
        for (int i = 0; i < 40; i++) step(1'b0, 3);
        step(1'b1, 3);
        step(1'b1, 3);
        for (int i = 0; i < 14; i++) step(1'b0, 3);
        step(1'b1, 1);
        step(1'b1, 1);
        step(1'b0, 1);
        for (int i = 0; i < 8; i++) step(1'b1, 1);
        for (int i = 0; i < 20 && !m_last[2]; i++) step(1'b1, 2);
        do_reset();
        step(1'b0, 7);
        step(1'b0, 7);
        for (int i = 0; i < 20; i++) step(1'b1, 15);
        e  = 1'b1;
        dv = 2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 10 == 0) e = ~e;
            if ($urandom % 6 == 0) dv = int'($urandom % 16);
            step(e, dv);
            if ($urandom % 700 == 0) do_reset();
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
